// File: rtl/flash_pkg.sv
// flash_pkg: shared op encodings, JEDEC command constants, sequencer states and ROM entry type
package flash_pkg;
  typedef enum logic [1:0] {OP_PROGRAM, OP_SECTOR_ERASE, OP_CHIP_ERASE, OP_RESET} op_e;
  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, P_RD, P_GAP, RST_W, FIN} state_e;
  localparam logic [10:0] UNLOCK_A1 = 11'h555;
  localparam logic [10:0] UNLOCK_A2 = 11'h2AA;
  localparam logic [7:0] D_UNLOCK1 = 8'hAA;
  localparam logic [7:0] D_UNLOCK2 = 8'h55;
  localparam logic [7:0] D_PROGRAM = 8'hA0;
  localparam logic [7:0] D_ERASE = 8'h80;
  localparam logic [7:0] D_SECTOR = 8'h30;
  localparam logic [7:0] D_CHIP = 8'h10;
  localparam logic [7:0] D_RESET = 8'hF0;
  typedef struct packed {
    logic addr_sel;
    logic data_sel;
    logic [10:0] addr;
    logic [7:0] data;
    logic last;
  } rom_t;
endpackage

// File: rtl/flash_cmd_sequencer_if.sv
// flash_cmd_sequencer_if: requester-side handshake (CMD_* in, DONE/ERROR/BUSY/CMD_READY out)
interface flash_cmd_sequencer_if import flash_pkg::*; #(parameter int ADDR_W = 19) ();
  logic CMD_VALID;
  logic CMD_READY;
  op_e CMD_OP;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [15:0] CMD_DATA;
  logic DONE;
  logic ERROR;
  logic BUSY;
  modport master (output CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, input CMD_READY, DONE, ERROR, BUSY);
  modport slave (input CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, output CMD_READY, DONE, ERROR, BUSY);
endinterface

// File: rtl/flash_cmd_rom.sv
// flash_cmd_rom: (op, step) -> write-cycle entry; addr_sel/data_sel pick the latched command address/data
module flash_cmd_rom import flash_pkg::*; (
  input op_e op,
  input logic [2:0] step,
  output rom_t rom
);
  always_comb begin
    rom = '{addr_sel: 1'b0, data_sel: 1'b0, addr: UNLOCK_A1, data: D_UNLOCK1, last: 1'b0};
    if (op == OP_RESET) rom = '{addr_sel: 1'b0, data_sel: 1'b0, addr: 11'h000, data: D_RESET, last: 1'b1};
    else if (step == 3'd1 || step == 3'd4) rom = '{addr_sel: 1'b0, data_sel: 1'b0, addr: UNLOCK_A2, data: D_UNLOCK2, last: 1'b0};
    else if (step == 3'd2) rom.data = op == OP_PROGRAM ? D_PROGRAM : D_ERASE;
    else if (op == OP_PROGRAM && step == 3'd3) rom = '{addr_sel: 1'b1, data_sel: 1'b1, addr: 11'h000, data: 8'h00, last: 1'b1};
    else if (step == 3'd5) rom = op == OP_SECTOR_ERASE ?
      '{addr_sel: 1'b1, data_sel: 1'b0, addr: 11'h000, data: D_SECTOR, last: 1'b1} :
      '{addr_sel: 1'b0, data_sel: 1'b0, addr: UNLOCK_A1, data: D_CHIP, last: 1'b1};
  end
endmodule

// File: rtl/flash_cmd_sequencer.sv
// flash_cmd_sequencer: JEDEC write scripts onto the flash pins, then DQ6/DQ5 toggle polling
// Ports: CLK/RESET_n; cmd (slave handshake); FLASH_* address, data, strobes and read data.
module flash_cmd_sequencer import flash_pkg::*; #(
  parameter int ADDR_W = 19,
  parameter int T_WE = 4,
  parameter int T_OE = 3,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
  input logic CLK,
  input logic RESET_n,
  flash_cmd_sequencer_if.slave cmd,
  output logic [ADDR_W-1:0] FLASH_ADDR,
  output logic [15:0] FLASH_DQ_OUT,
  output logic FLASH_DQ_OE,
  input logic [15:0] FLASH_DQ_IN,
  output logic FLASH_CE_n,
  output logic FLASH_WE_n,
  output logic FLASH_OE_n
);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d, faddr_q, faddr_d;
  logic [15:0] data_q, data_d, fdq_q, fdq_d, cur_q, cur_d, prev_q, prev_d;
  logic [2:0] step_q, step_d;
  logic [7:0] tmr_q, tmr_d;
  logic [23:0] poll_q, poll_d, poll_inc;
  logic [1:0] cnt_q, cnt_d;
  logic dq5_q, dq5_d, error_q, error_d, done_q, done_d, busy_q, busy_d, ready_q, ready_d;
  logic ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d, dq_oe_q, dq_oe_d, last_q, last_d;
  logic toggled, wr;
  rom_t rom;
  flash_cmd_rom u_rom (.op(op_d), .step(step_d), .rom(rom));
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    data_d = data_q;
    step_d = step_q;
    tmr_d = tmr_q;
    poll_d = poll_q;
    cur_d = cur_q;
    prev_d = prev_q;
    cnt_d = cnt_q;
    dq5_d = dq5_q;
    error_d = error_q;
    poll_inc = &poll_q ? poll_q : poll_q + 24'd1;
    toggled = |((cur_q ^ prev_q) & 16'h0040);
    case (state_q)
      IDLE: if (cmd.CMD_VALID) begin
        state_d = W_SETUP;
        op_d = cmd.CMD_OP;
        addr_d = cmd.CMD_ADDR;
        data_d = cmd.CMD_DATA;
        step_d = 3'd0;
        poll_d = 24'd0;
        cnt_d = 2'd0;
        dq5_d = 1'b0;
        error_d = 1'b0;
      end
      W_SETUP, RST_W: begin
        state_d = W_PULSE;
        tmr_d = 8'(T_WE - 1);
      end
      W_PULSE: if (tmr_q == 8'd0) state_d = W_HOLD; else tmr_d = tmr_q - 8'd1;
      W_HOLD: if (!last_q) begin
        state_d = W_SETUP;
        step_d = step_q + 3'd1;
      end else if (op_q == OP_RESET) state_d = FIN;
      else begin
        state_d = P_RD;
        tmr_d = 8'(T_OE - 1);
      end
      P_RD: if (tmr_q == 8'd0) begin
        state_d = P_GAP;
        cur_d = FLASH_DQ_IN;
        prev_d = cur_q;
        cnt_d = cnt_q == 2'd2 ? 2'd2 : cnt_q + 2'd1;
      end else tmr_d = tmr_q - 8'd1;
      P_GAP: begin
        poll_d = poll_inc;
        if (cnt_q == 2'd2 && !toggled) state_d = FIN;
        else if ((cnt_q == 2'd2 && dq5_q) || poll_inc == TIMEOUT) begin
          // failed op: abort through a single F0 write, reusing the RESET script entry
          state_d = RST_W;
          error_d = 1'b1;
          op_d = OP_RESET;
          step_d = 3'd0;
        end else begin
          state_d = P_RD;
          tmr_d = 8'(T_OE - 1);
          // DQ5 seen while toggling: restart the pair so the confirming reads are fresh
          if (cnt_q == 2'd2 && cur_q[5]) begin
            dq5_d = 1'b1;
            cnt_d = 2'd0;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so pins change cleanly on the edge
    wr = state_d inside {W_SETUP, W_PULSE, W_HOLD, RST_W};
    faddr_d = wr ? (rom.addr_sel ? addr_d : ADDR_W'(rom.addr)) : faddr_q;
    fdq_d = wr ? (rom.data_sel ? data_d : {8'h00, rom.data}) : fdq_q;
    last_d = wr ? rom.last : last_q;
    ce_n_d = state_d inside {IDLE, FIN};
    we_n_d = state_d != W_PULSE;
    oe_n_d = state_d != P_RD;
    dq_oe_d = wr;
    done_d = state_d == FIN;
    busy_d = state_d != IDLE;
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      op_q <= OP_PROGRAM;
      addr_q <= '0;
      data_q <= '0;
      step_q <= '0;
      tmr_q <= '0;
      poll_q <= '0;
      cur_q <= '0;
      prev_q <= '0;
      cnt_q <= '0;
      dq5_q <= 1'b0;
      error_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      ready_q <= 1'b1;
      ce_n_q <= 1'b1;
      we_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      dq_oe_q <= 1'b0;
      faddr_q <= '0;
      fdq_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      data_q <= data_d;
      step_q <= step_d;
      tmr_q <= tmr_d;
      poll_q <= poll_d;
      cur_q <= cur_d;
      prev_q <= prev_d;
      cnt_q <= cnt_d;
      dq5_q <= dq5_d;
      error_q <= error_d;
      done_q <= done_d;
      busy_q <= busy_d;
      ready_q <= ready_d;
      ce_n_q <= ce_n_d;
      we_n_q <= we_n_d;
      oe_n_q <= oe_n_d;
      dq_oe_q <= dq_oe_d;
      faddr_q <= faddr_d;
      fdq_q <= fdq_d;
      last_q <= last_d;
    end
  end
  assign cmd.CMD_READY = ready_q;
  assign cmd.DONE = done_q;
  assign cmd.ERROR = error_q;
  assign cmd.BUSY = busy_q;
  assign FLASH_ADDR = faddr_q;
  assign FLASH_DQ_OUT = fdq_q;
  assign FLASH_DQ_OE = dq_oe_q;
  assign FLASH_CE_n = ce_n_q;
  assign FLASH_WE_n = we_n_q;
  assign FLASH_OE_n = oe_n_q;
endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb_flash_cmd_sequencer: scoreboarded write scripts plus a DQ6/DQ5 flash model for the sequencer
module tb_flash_cmd_sequencer;
  import flash_pkg::*;
  localparam int AW = 19;
  localparam int TWE = 4;
  localparam int TOE = 3;
  typedef struct packed {logic [AW-1:0] a; logic [15:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  flash_cmd_sequencer_if #(.ADDR_W(AW)) ifc ();
  flash_cmd_sequencer_if #(.ADDR_W(AW)) ifc_t ();
  logic [AW-1:0] f_addr, t_addr;
  logic [15:0] f_dq, f_in, t_dq, t_in;
  logic f_dqoe, f_ce, f_we, f_oe, t_dqoe, t_ce, t_we, t_oe;
  flash_cmd_sequencer #(.ADDR_W(AW), .T_WE(TWE), .T_OE(TOE)) dut (
    .CLK(clk), .RESET_n(rst_n), .cmd(ifc),
    .FLASH_ADDR(f_addr), .FLASH_DQ_OUT(f_dq), .FLASH_DQ_OE(f_dqoe), .FLASH_DQ_IN(f_in),
    .FLASH_CE_n(f_ce), .FLASH_WE_n(f_we), .FLASH_OE_n(f_oe)
  );
  flash_cmd_sequencer #(.ADDR_W(AW), .T_WE(TWE), .T_OE(TOE), .TIMEOUT(24'd8)) dut_t (
    .CLK(clk), .RESET_n(rst_n), .cmd(ifc_t),
    .FLASH_ADDR(t_addr), .FLASH_DQ_OUT(t_dq), .FLASH_DQ_OE(t_dqoe), .FLASH_DQ_IN(t_in),
    .FLASH_CE_n(t_ce), .FLASH_WE_n(t_we), .FLASH_OE_n(t_oe)
  );
  int n_chk = 0;
  int n_pass = 0;
  int rd_cnt = 0;
  int tog_lim = 3;
  logic dq5_m = 1'b0;
  logic dq6_m;
  int t_rd = 0;
  int t_wr = 0;
  logic [AW-1:0] t_last_a;
  logic [15:0] t_last_d;
  int n_wr = 0;
  int n_done = 0;
  int we_w = 0;
  logic we_p = 1'b1;
  wr_t exp_q[$];
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // Flash model: read k returns DQ6 = k[0] until tog_lim, then holds, so it settles on read tog_lim+1
  always @(negedge f_oe) rd_cnt++;
  always_comb dq6_m = (rd_cnt < tog_lim) ? rd_cnt[0] : tog_lim[0];
  assign f_in = {9'd0, dq6_m, dq5_m, 5'd0};
  always @(negedge t_oe) t_rd++;
  assign t_in = {9'd0, t_rd[0], 6'd0};
  always @(posedge t_we) begin
    t_wr++;
    t_last_a = t_addr;
    t_last_d = t_dq;
  end
  always @(posedge clk) begin
    #1;
    if (ifc.DONE) n_done++;
    if (!rst_n) begin
      we_p = 1'b1;
      we_w = 0;
    end else begin
      if (!f_we) we_w++;
      if (!f_we && !f_oe) chk("we_oe_overlap", {f_we, f_oe}, 2'b11);
      if (!f_oe && f_dqoe) chk("dq_oe_in_read", f_dqoe, 0);
      if (f_we && !we_p) begin
        n_wr++;
        if (exp_q.size() == 0) chk("wr_extra", {f_addr, f_dq}, 0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", f_addr, e.a);
          chk("wr_data", f_dq, e.d);
          chk("we_width", we_w, TWE);
        end
        we_w = 0;
      end
      we_p = f_we;
    end
  end
  task automatic push(logic [AW-1:0] a, logic [15:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask
  task automatic push_script(op_e op, logic [AW-1:0] a, logic [15:0] d);
    if (op == OP_RESET) push(0, 16'h00F0);
    else begin
      push(19'h555, 16'h00AA);
      push(19'h2AA, 16'h0055);
      if (op == OP_PROGRAM) begin
        push(19'h555, 16'h00A0);
        push(a, d);
      end else begin
        push(19'h555, 16'h0080);
        push(19'h555, 16'h00AA);
        push(19'h2AA, 16'h0055);
        if (op == OP_SECTOR_ERASE) push(a, 16'h0030);
        else push(19'h555, 16'h0010);
      end
    end
  endtask
  task automatic issue(op_e op, logic [AW-1:0] a, logic [15:0] d, bit hold);
    int k = 0;
    while (!ifc.CMD_READY && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("ready_before_issue", ifc.CMD_READY, 1);
    ifc.CMD_VALID = 1'b1;
    ifc.CMD_OP = op;
    ifc.CMD_ADDR = a;
    ifc.CMD_DATA = d;
    @(posedge clk);
    #1;
    if (!hold) ifc.CMD_VALID = 1'b0;
    chk("busy_after_accept", ifc.BUSY, 1);
    chk("error_cleared_on_accept", ifc.ERROR, 0);
  endtask
  task automatic wait_done(output int lat);
    int c = 0;
    while (!ifc.DONE && c < 5000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("done_seen", ifc.DONE, 1);
    lat = c + 1;
  endtask
  task automatic after_done(int done_base);
    @(posedge clk);
    #1;
    chk("done_single_pulse", ifc.DONE, 0);
    chk("ready_after_done", ifc.CMD_READY, 1);
    chk("busy_after_done", ifc.BUSY, 0);
    chk("done_count", n_done - done_base, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask
  initial begin
    int lat, nd, base;
    ifc.CMD_VALID = 1'b0;
    ifc.CMD_OP = OP_PROGRAM;
    ifc.CMD_ADDR = '0;
    ifc.CMD_DATA = '0;
    ifc_t.CMD_VALID = 1'b0;
    ifc_t.CMD_OP = OP_PROGRAM;
    ifc_t.CMD_ADDR = '0;
    ifc_t.CMD_DATA = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n", f_ce, 1);
    chk("rst_we_n", f_we, 1);
    chk("rst_oe_n", f_oe, 1);
    chk("rst_dq_oe", f_dqoe, 0);
    chk("rst_busy", ifc.BUSY, 0);
    chk("rst_done", ifc.DONE, 0);
    chk("rst_error", ifc.ERROR, 0);
    chk("rst_ready", ifc.CMD_READY, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // PROGRAM, settles on read 4
    tog_lim = 3;
    dq5_m = 1'b0;
    rd_cnt = 0;
    nd = n_done;
    push_script(OP_PROGRAM, 19'h12345, 16'hBEEF);
    issue(OP_PROGRAM, 19'h12345, 16'hBEEF, 0);
    wait_done(lat);
    chk("prog_error", ifc.ERROR, 0);
    chk("prog_reads", rd_cnt, 4);
    chk("prog_latency", lat, 4 * (TWE + 2) + 4 * (TOE + 1) + 1);
    after_done(nd);
    // SECTOR_ERASE, DQ6 toggles for 50 reads
    tog_lim = 50;
    rd_cnt = 0;
    nd = n_done;
    push_script(OP_SECTOR_ERASE, 19'h40000, 16'h0000);
    issue(OP_SECTOR_ERASE, 19'h40000, 16'h0000, 0);
    wait_done(lat);
    chk("sect_error", ifc.ERROR, 0);
    chk("sect_reads", rd_cnt, 51);
    chk("sect_latency", lat, 6 * (TWE + 2) + 51 * (TOE + 1) + 1);
    after_done(nd);
    // CHIP_ERASE failing with DQ5: detect pair + confirm pair, then F0 abort write
    tog_lim = 1000000;
    dq5_m = 1'b1;
    rd_cnt = 0;
    nd = n_done;
    push_script(OP_CHIP_ERASE, 19'h00000, 16'h0000);
    push(0, 16'h00F0);
    issue(OP_CHIP_ERASE, 19'h00000, 16'h0000, 0);
    wait_done(lat);
    chk("chip_error", ifc.ERROR, 1);
    chk("chip_reads", rd_cnt, 4);
    chk("chip_latency", lat, 7 * (TWE + 2) + 4 * (TOE + 1) + 1);
    after_done(nd);
    chk("error_sticky", ifc.ERROR, 1);
    // VALID held through BUSY with a different op; second accept only after DONE
    tog_lim = 3;
    dq5_m = 1'b0;
    rd_cnt = 0;
    nd = n_done;
    push_script(OP_PROGRAM, 19'h00100, 16'h1234);
    issue(OP_PROGRAM, 19'h00100, 16'h1234, 1);
    ifc.CMD_OP = OP_RESET;
    wait_done(lat);
    chk("held_prog_error", ifc.ERROR, 0);
    chk("held_prog_reads", rd_cnt, 4);
    chk("held_prog_latency", lat, 4 * (TWE + 2) + 4 * (TOE + 1) + 1);
    push_script(OP_RESET, 0, 0);
    @(posedge clk);
    #1;
    chk("idle_between_ready", ifc.CMD_READY, 1);
    chk("idle_between_busy", ifc.BUSY, 0);
    @(posedge clk);
    #1;
    chk("second_accept_busy", ifc.BUSY, 1);
    ifc.CMD_VALID = 1'b0;
    wait_done(lat);
    chk("reset_op_latency", lat, (TWE + 2) + 1);
    chk("reset_op_reads", rd_cnt, 4);
    after_done(nd + 1);
    // async reset during W_PULSE of step 2
    rd_cnt = 0;
    base = n_wr;
    push_script(OP_PROGRAM, 19'h00ABC, 16'h5A5A);
    issue(OP_PROGRAM, 19'h00ABC, 16'h5A5A, 0);
    lat = 0;
    while (!(n_wr == base + 2 && !f_we) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("reached_step2_pulse", {n_wr - base, 1'b0, f_we}, {32'd2, 2'b00});
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_we_n", f_we, 1);
    chk("arst_ce_n", f_ce, 1);
    chk("arst_oe_n", f_oe, 1);
    chk("arst_dq_oe", f_dqoe, 0);
    chk("arst_busy", ifc.BUSY, 0);
    chk("arst_ready", ifc.CMD_READY, 1);
    chk("arst_error", ifc.ERROR, 0);
    chk("arst_pending_writes", exp_q.size(), 2);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tog_lim = 3;
    rd_cnt = 0;
    nd = n_done;
    push_script(OP_PROGRAM, 19'h7FFFF, 16'hC0DE);
    issue(OP_PROGRAM, 19'h7FFFF, 16'hC0DE, 0);
    wait_done(lat);
    chk("post_rst_error", ifc.ERROR, 0);
    chk("post_rst_latency", lat, 4 * (TWE + 2) + 4 * (TOE + 1) + 1);
    after_done(nd);
    // TIMEOUT = 8 instance, DQ6 toggles forever
    t_rd = 0;
    t_wr = 0;
    ifc_t.CMD_VALID = 1'b1;
    ifc_t.CMD_OP = OP_PROGRAM;
    ifc_t.CMD_ADDR = 19'h00042;
    ifc_t.CMD_DATA = 16'h0F0F;
    @(posedge clk);
    #1;
    ifc_t.CMD_VALID = 1'b0;
    lat = 0;
    while (!ifc_t.DONE && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("to_done_seen", ifc_t.DONE, 1);
    chk("to_reads", t_rd, 8);
    chk("to_error", ifc_t.ERROR, 1);
    chk("to_writes", t_wr, 5);
    chk("to_last_write", {t_last_a, t_last_d}, {19'h00000, 16'h00F0});
    @(posedge clk);
    #1;
    chk("to_ready", ifc_t.CMD_READY, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
